hazard_ctrl: RTL

- Central pipeline sequencer for the 5-stage processor (IF/ID/EX/MEM/WB).
- Detects load-use hazards, branch redirects, RAM wait and halt requests.
- Drives write-enable and flush/bubble controls for the PC and all pipeline registers.
- Sits beside the stages; consumes ID/EX and EX/MEM fields, emits per-stage controls.

---
 rtl/hazard_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, branch flushes, RAM wait and halt drain.
// Performance counters are built only when HAZ_PERF_CNT_EN is defined; otherwise the ports read 0.
module hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 2,
  parameter int DRAIN_CYCLES    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic        IF_ID_UsesRt,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rd,
  input  logic        EX_MEM_Branch,
  input  logic        mem_busy,
  input  logic        halt_req,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Write,
  output logic        ID_EX_Bubble,
  output logic        EX_MEM_Write,
  output logic        EX_MEM_Flush,
  output logic        MEM_WB_Bubble,
  output logic        halted,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] wait_cnt
);

  // state    | meaning
  // RUN      | normal issue, hazards and halt evaluated
  // LU_STALL | remaining load-use bubbles being inserted
  // DRAIN    | halt accepted, older instructions retiring
  // HALT     | core stopped until reset
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    DRAIN    = 2'd2,
    HALT     = 2'd3
  } ctrlState_t;

  localparam logic [3:0] LU_LOAD    = 4'(LU_STALL_CYCLES - 1);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  ctrlState_t state, stateNext;
  logic [3:0] stallCnt, stallCntNext;
  logic [3:0] drainCnt, drainCntNext;
  logic       loadUse;
  logic       branchTaken;

  assign loadUse = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                   ((ID_EX_Rd == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rd == IF_ID_Rt)));
  assign branchTaken = !mem_busy && EX_MEM_Branch && (state != HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      stallCnt <= 4'd0;
      drainCnt <= 4'd0;
    end else begin
      state    <= stateNext;
      stallCnt <= stallCntNext;
      drainCnt <= drainCntNext;
    end
  end

  always_comb begin
    stateNext     = state;
    stallCntNext  = stallCnt;
    drainCntNext  = drainCnt;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Write   = 1'b1;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Write  = 1'b1;
    EX_MEM_Flush  = 1'b0;
    MEM_WB_Bubble = 1'b0;

    if (mem_busy) begin
      // Whole pipe frozen; a pending branch stays in EX/MEM and fires later.
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end else if (branchTaken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      EX_MEM_Flush = 1'b1;
      stateNext    = RUN;
      stallCntNext = 4'd0;
      drainCntNext = 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (loadUse) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              stallCntNext = LU_LOAD;
              stateNext    = LU_STALL;
            end
          end else if (halt_req) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            drainCntNext = DRAIN_LOAD;
            stateNext    = DRAIN;
          end
        end
        LU_STALL: begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          if (stallCnt <= 4'd1) begin
            stallCntNext = 4'd0;
            stateNext    = RUN;
          end else begin
            stallCntNext = stallCnt - 4'd1;
          end
        end
        DRAIN: begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          if (drainCnt <= 4'd1) begin
            drainCntNext = 4'd0;
            stateNext    = HALT;
          end else begin
            drainCntNext = drainCnt - 4'd1;
          end
        end
        HALT: begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
        end
        default: stateNext = RUN;
      endcase
    end
  end

  assign halted     = (state == HALT);
  assign ctrl_state = state;

`ifdef HAZ_PERF_CNT_EN
  logic        incStall, incFlush, incWait;
  logic [31:0] stallReg, flushReg, waitReg;

  assign incWait  = mem_busy;
  assign incFlush = branchTaken;
  assign incStall = !mem_busy && !branchTaken &&
                    (((state == RUN) && loadUse) || (state == LU_STALL));

  // Saturating at all-ones so long runs never wrap back to small values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallReg <= 32'd0;
      flushReg <= 32'd0;
      waitReg  <= 32'd0;
    end else begin
      if (incStall && (stallReg != 32'hFFFF_FFFF)) stallReg <= stallReg + 32'd1;
      if (incFlush && (flushReg != 32'hFFFF_FFFF)) flushReg <= flushReg + 32'd1;
      if (incWait  && (waitReg  != 32'hFFFF_FFFF)) waitReg  <= waitReg  + 32'd1;
    end
  end

  assign stall_cnt = stallReg;
  assign flush_cnt = flushReg;
  assign wait_cnt  = waitReg;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
  assign wait_cnt  = 32'd0;
`endif

endmodule
